// File: rtl/uart_pkg.sv
// Shared types and constants for the oversampling UART receiver.
// Sample points and the stop decision tick live here.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    localparam int OVERSAMPLE = 8;
    localparam logic [2:0] LAST_TICK = 3'(OVERSAMPLE - 1);
    localparam logic [2:0] SAMPLE_T0 = 3'd3;
    localparam logic [2:0] SAMPLE_T1 = 3'd4;
    localparam logic [2:0] SAMPLE_T2 = 3'd5;
    localparam logic [2:0] STOP_DECIDE_TICK = 3'd5;

    function automatic logic maj3(
        input logic a,
        input logic b,
        input logic c
    );
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO for received {ferr, byte} entries.
// When empty the output holds the last popped entry.
module sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic [WIDTH-1:0] last_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (AW + 1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign count   = cnt;
    assign dout    = empty ? last_q : mem[rd_ptr];

    // Storage write; contents need no reset since cnt gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer, occupancy and last-popped bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            last_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                last_q <= mem[rd_ptr];
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (AW + 1)'(1);
                2'b01:   cnt <= cnt - (AW + 1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 receiver with 8x oversampling, 3-sample majority vote,
// break lockout and a small show-ahead receive FIFO.
module uart_rx
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          bitxce,
    input  logic                          rx,
    input  logic                          rd,
    input  logic                          clr_ovr,
    output logic [7:0]                    dout,
    output logic                          ferr,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overrun,
    output logic                          bytercvd
);

    logic       rx_m;
    logic       rx_s;
    state_t     state;
    logic [2:0] tick;
    logic [2:0] bitn;
    logic       armed;
    logic [2:0] smp;
    logic [7:0] shreg;
    logic       maj_mid;
    logic       maj_stop;
    logic       push;
    logic       accept;
    logic       full;
    logic [8:0] fifo_dout;

    assign maj_mid  = maj3(smp[0], smp[1], smp[2]);
    assign maj_stop = maj3(smp[0], smp[1], rx_s);
    assign push     = bitxce && (state == STOP)
                   && (tick == STOP_DECIDE_TICK);
    assign accept   = push && (!full || rd);
    assign {ferr, dout} = fifo_dout;

    // Two-flop synchronizer; idles high so reset looks like a quiet line.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    // Capture the three mid-bit samples for the majority vote.
    always_ff @(posedge clk) begin
        if (rst) begin
            smp <= '0;
        end else if (bitxce && (state != IDLE)) begin
            if (tick == SAMPLE_T0) smp[0] <= rx_s;
            if (tick == SAMPLE_T1) smp[1] <= rx_s;
            if (tick == SAMPLE_T2) smp[2] <= rx_s;
        end
    end

    // Frame FSM: start qualification, data shift, early stop decision.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            tick  <= '0;
            bitn  <= '0;
            armed <= 1'b0;
            shreg <= '0;
        end else if (bitxce) begin
            unique case (state)
                IDLE: begin
                    if (!rx_s && armed) begin
                        state <= START;
                        tick  <= '0;
                        armed <= 1'b0;
                    end else if (rx_s) begin
                        armed <= 1'b1;
                    end
                end
                START: begin
                    tick <= tick + 3'd1;
                    if (tick == LAST_TICK) begin
                        if (maj_mid) begin
                            state <= IDLE;
                        end else begin
                            state <= DATA;
                            bitn  <= '0;
                        end
                    end
                end
                DATA: begin
                    tick <= tick + 3'd1;
                    if (tick == LAST_TICK) begin
                        shreg <= {maj_mid, shreg[7:1]};
                        bitn  <= bitn + 3'd1;
                        if (bitn == 3'd7) begin
                            state <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (tick == STOP_DECIDE_TICK) begin
                        state <= IDLE;
                        tick  <= '0;
                    end else begin
                        tick <= tick + 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Receive pulse and sticky overrun; a set beats a clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            bytercvd <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            bytercvd <= accept;
            if (push && full && !rd) begin
                overrun <= 1'b1;
            end else if (clr_ovr) begin
                overrun <= 1'b0;
            end
        end
    end

    sync_fifo #(
        .WIDTH (9),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (rd),
        .din   ({~maj_stop, shreg}),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty),
        .count (count)
    );

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are built from bit lists,
// expected {ferr, byte} entries are queued and checked by a monitor.
module tb_uart_rx;

    localparam int DEPTH = 4;
    localparam int BITCLK = 104;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       rd;
    logic       clr_ovr;
    logic       bitxce;
    logic [7:0] dout;
    logic       ferr;
    logic       empty;
    logic [2:0] count;
    logic       overrun;
    logic       bytercvd;

    int unsigned cyc = 0;
    int vectors = 0;
    int errors = 0;
    int rcvd_n = 0;
    logic [8:0] exp_q[$];
    logic [8:0] model[$];
    logic [8:0] last = '0;
    logic ovr_prev = 1'b0;

    uart_rx #(.FIFO_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .bitxce   (bitxce),
        .rx       (rx),
        .rd       (rd),
        .clr_ovr  (clr_ovr),
        .dout     (dout),
        .ferr     (ferr),
        .empty    (empty),
        .count    (count),
        .overrun  (overrun),
        .bytercvd (bytercvd)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    assign bitxce = (cyc % 13) == 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: reference FIFO follows rd/bytercvd/overrun events.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            model.delete();
            exp_q.delete();
            last = '0;
            ovr_prev = 1'b0;
            check("rst_count", 32'(count), 0);
            check("rst_empty", 32'(empty), 1);
            check("rst_head", 32'({ferr, dout}), 0);
            check("rst_ovr", 32'(overrun), 0);
            check("rst_rcvd", 32'(bytercvd), 0);
        end else begin
            if (rd && model.size() > 0) last = model.pop_front();
            if (bytercvd) begin
                rcvd_n++;
                vectors++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_byte: got %0h expected none",
                             {ferr, dout});
                end else begin
                    model.push_back(exp_q.pop_front());
                end
            end
            if (overrun && !ovr_prev) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL unexpected_overrun: got 1 expected 0");
                end else begin
                    void'(exp_q.pop_front());
                    check("drop_when_full", model.size(), DEPTH);
                end
            end
            ovr_prev = overrun;
            check("count", 32'(count), model.size());
            check("empty", 32'(empty), 32'(model.size() == 0));
            if (model.size() > 0)
                check("head", 32'({ferr, dout}), 32'(model[0]));
            else
                check("hold", 32'({ferr, dout}), 32'(last));
        end
    end

    task automatic idle(input int bits);
        rx = 1'b1;
        repeat (bits * BITCLK) @(negedge clk);
    endtask

    task automatic sync_tick();
        while (cyc % 13 != 1) @(negedge clk);
    endtask

    // One 8N1 frame; optional rd strobe lands on the push edge.
    task automatic send(input logic [7:0] data, input logic stop_bit,
                        input logic pop_at_push);
        logic [9:0] fr;
        fr = {stop_bit, data, 1'b0};
        exp_q.push_back({~stop_bit, data});
        sync_tick();
        for (int c = 0; c < 10 * BITCLK; c++) begin
            rx = fr[c / BITCLK];
            rd = pop_at_push && (c == 1026);
            @(negedge clk);
        end
        rd = 1'b0;
        rx = 1'b1;
    endtask

    task automatic drain();
        for (int g = 0; g < 16 && model.size() > 0; g++) begin
            rd = 1'b1;
            @(negedge clk);
            rd = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        #950000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        logic [7:0] d;
        logic s;
        logic prev_s;
        rst = 1'b1;
        rx = 1'b1;
        rd = 1'b0;
        clr_ovr = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_empty", 32'(empty), 1);
        check("reset_count", 32'(count), 0);
        idle(2);

        n0 = rcvd_n;
        send(8'hA5, 1'b1, 1'b0);
        check("t1_rcvd", rcvd_n - n0, 1);
        check("t1_dout", 32'(dout), 32'hA5);
        check("t1_ferr", 32'(ferr), 0);
        check("t1_count", 32'(count), 1);
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        check("t1_empty", 32'(empty), 1);

        n0 = rcvd_n;
        send(8'h55, 1'b1, 1'b0);
        send(8'h0F, 1'b1, 1'b0);
        send(8'hF0, 1'b1, 1'b0);
        check("t2_count", 32'(count), 3);
        check("t2_head", 32'(dout), 32'h55);
        check("t2_rcvd", rcvd_n - n0, 3);
        drain();

        for (int i = 1; i <= 5; i++) send(8'(i), 1'b1, 1'b0);
        check("t3_count", 32'(count), 4);
        check("t3_ovr", 32'(overrun), 1);
        check("t3_head", 32'(dout), 32'h01);
        clr_ovr = 1'b1;
        @(negedge clk);
        clr_ovr = 1'b0;
        check("t3_clr", 32'(overrun), 0);
        send(8'h06, 1'b1, 1'b1);
        check("t3_rdpush_ovr", 32'(overrun), 0);
        check("t3_rdpush_cnt", 32'(count), 4);
        check("t3_rdpush_head", 32'(dout), 32'h02);
        drain();
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        @(negedge clk);
        check("t3_rd_empty_cnt", 32'(count), 0);
        check("t3_rd_empty_hold", 32'(dout), 32'h06);

        n0 = rcvd_n;
        sync_tick();
        rx = 1'b0;
        repeat (26) @(negedge clk);
        idle(2);
        check("t4_glitch", rcvd_n - n0, 0);
        check("t4_count", 32'(count), 0);
        send(8'h99, 1'b1, 1'b0);
        check("t4_after", 32'(dout), 32'h99);
        drain();

        send(8'h3C, 1'b0, 1'b0);
        check("t5_dout", 32'(dout), 32'h3C);
        check("t5_ferr", 32'(ferr), 1);
        drain();
        idle(1);

        n0 = rcvd_n;
        exp_q.push_back(9'h100);
        sync_tick();
        rx = 1'b0;
        repeat (30 * BITCLK) @(negedge clk);
        idle(2);
        check("t6_break_n", rcvd_n - n0, 1);
        check("t6_break_cnt", 32'(count), 1);
        check("t6_break_byte", 32'({ferr, dout}), 32'h100);
        sync_tick();
        rx = 1'b0;
        repeat (BITCLK) @(negedge clk);
        rx = 1'b1;
        repeat (BITCLK) @(negedge clk);
        rx = 1'b0;
        repeat (BITCLK) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rx = 1'b1;
        check("t6_rst_cnt", 32'(count), 0);
        check("t6_rst_empty", 32'(empty), 1);
        check("t6_rst_head", 32'({ferr, dout}), 0);
        idle(2);
        send(8'h7E, 1'b1, 1'b0);
        check("t6_7e", 32'({ferr, dout}), 32'h07E);
        check("t6_7e_cnt", 32'(count), 1);
        drain();

        prev_s = 1'b1;
        for (int i = 0; i < 12; i++) begin
            d = 8'($urandom_range(0, 255));
            s = ($urandom_range(0, 3) != 0);
            if (model.size() >= 3 || $urandom_range(0, 1) == 1) drain();
            if (!prev_s) idle(1);
            else idle($urandom_range(0, 2));
            send(d, s, 1'b0);
            prev_s = s;
        end
        drain();
        check("rand_pending", exp_q.size(), 0);
        check("rand_count", 32'(count), 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
